// File: rtl/cpu_fetch_unit.sv
// Instruction fetch: holds the PC, runs one bus read per start and strobes the word into the IR.
// Latency: start->bus_req 1 cycle, ack->ir_wr same cycle, ack->done 1 cycle (min 2 cycles start->done).
// Backpressure: WAIT holds bus_req/bus_addr until ack/err; optional timeout under CPU_FETCH_TIMEOUT_EN.
`timescale 1ns/1ps
module cpu_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pc_wr,
  input  logic [31:0] pc_in,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata,
  output logic [31:0] ir_data,
  output logic        ir_wr
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_BUS_ERR  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  // The timeout counter is 16 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("cpu_fetch_unit: TIMEOUT_CYCLES out of range 1..65535");
  end

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] fetch_addr;

`ifdef CPU_FETCH_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
`endif

  assign fetch_addr = pc_wr ? pc_in : pc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    fault_d = fault_q;
    cause_d = cause_q;
`ifdef CPU_FETCH_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = fetch_addr;
          fault_d = 1'b0;
          cause_d = CAUSE_NONE;
          if (fetch_addr[1:0] != 2'b00) begin
            fault_d = 1'b1;
            cause_d = CAUSE_MISALIGN;
            state_d = S_DONE;
          end else begin
            addr_d  = fetch_addr;
            req_d   = 1'b1;
            state_d = S_WAIT;
`ifdef CPU_FETCH_TIMEOUT_EN
            tmo_cnt_d = 16'd0;
`endif
          end
        end else if (pc_wr) begin
          pc_d = pc_in;
        end
      end
      S_WAIT: begin
        // A response in the limit cycle beats the timeout.
        if (bus_err) begin
          req_d   = 1'b0;
          fault_d = 1'b1;
          cause_d = CAUSE_BUS_ERR;
          state_d = S_DONE;
        end else if (bus_ack) begin
          req_d   = 1'b0;
          state_d = S_DONE;
        end else begin
`ifdef CPU_FETCH_TIMEOUT_EN
          if (tmo_cnt_q == TMO_LAST) begin
            req_d   = 1'b0;
            fault_d = 1'b1;
            cause_d = CAUSE_TIMEOUT;
            state_d = S_DONE;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
          end
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      fault_q <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      fault_q <= fault_d;
      cause_q <= cause_d;
    end
  end

`ifdef CPU_FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_cnt_q <= 16'd0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`endif

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign fault       = fault_q;
  assign fault_cause = cause_q;
  assign bus_req     = req_q;
  assign bus_addr    = addr_q;
  assign ir_data     = bus_rdata;
  // Combinational so the IR captures bus_rdata on the same edge the bus completes.
  assign ir_wr       = (state_q == S_WAIT) & bus_ack & ~bus_err;

endmodule
